// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the fetch/MEM memory arbiter
package mem_arb_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and MEM stages
// One outstanding access at a time; a granted access ends on mem_ack or after TIMEOUT cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [ADDR_W-1:0] i_rdata,
    output logic              i_ready,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_wdata,
    output logic [ADDR_W-1:0] d_rdata,
    output logic              d_ready,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic              mem_ack,

    output logic              stall_f,
    output logic              stall_m,
    output logic              bus_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    grant_t           last_grant;
    logic [CNT_W-1:0] wait_cnt;

    logic             in_gnt;
    logic             timeout_hit;
    logic             done;
    logic             grant_i;
    logic             grant_d;

    assign in_gnt      = (state == GNT_I) || (state == GNT_D);
    // An ack arriving on the last allowed cycle completes normally rather than aborting.
    assign timeout_hit = in_gnt && !mem_ack && (wait_cnt == CNT_LAST);
    assign done        = in_gnt && (mem_ack || timeout_hit);

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    if (last_grant == GRANT_I) grant_d = 1'b1;
                    else                       grant_i = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_i) state_nxt = GNT_I;
                if (grant_d) state_nxt = GNT_D;
            end
            GNT_I, GNT_D: begin
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Memory-side request is latched at grant and held untouched until completion,
    // so requester deassertion mid-access cannot disturb the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            last_grant <= GRANT_I;
            wait_cnt   <= '0;
        end else if (grant_i) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= i_addr;
            mem_wdata  <= '0;
            last_grant <= GRANT_I;
            wait_cnt   <= '0;
        end else if (grant_d) begin
            mem_req    <= 1'b1;
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            last_grant <= GRANT_D;
            wait_cnt   <= '0;
        end else if (done) begin
            mem_req    <= 1'b0;
        end else if (in_gnt) begin
            wait_cnt   <= wait_cnt + CNT_W'(1);
        end
    end

    assign i_ready = (state == GNT_I) && (mem_ack || timeout_hit);
    assign d_ready = (state == GNT_D) && (mem_ack || timeout_hit);
    assign i_rdata = ((state == GNT_I) && mem_ack) ? mem_rdata : '0;
    assign d_rdata = ((state == GNT_D) && mem_ack) ? mem_rdata : '0;
    assign bus_err = timeout_hit;
    assign stall_f = i_req && !i_ready;
    assign stall_m = d_req && !d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with directed and randomized traffic
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ready, d_ready, mem_req, mem_we, stall_f, stall_m, bus_err;

    int n_pass  = 0;
    int n_total = 0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_f(stall_f), .stall_m(stall_m), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        @(negedge clk);
        n_total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'h0)
            $display("FAIL reset_mem: got %b %b %h %h want all zero", mem_req, mem_we, mem_addr, mem_wdata);
        else n_pass++;
        n_total++;
        if ({i_ready, d_ready, bus_err, stall_f, stall_m} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {i_ready, d_ready, bus_err, stall_f, stall_m});
        else n_pass++;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({mem_req, i_ready, d_ready, bus_err} !== 4'b0)
            $display("FAIL reset_release: got %b want 0000", {mem_req, i_ready, d_ready, bus_err});
        else n_pass++;
    endtask

    // Ack arrives in the 4th granted cycle, which with TIMEOUT=4 is also the timeout cycle.
    task automatic test_lone_fetch();
        do_reset();
        i_req = 1; i_addr = 32'h100;
        @(negedge clk);
        n_total++;
        if ({mem_req, stall_f} !== 2'b01)
            $display("FAIL fetch_pre_grant: got %b want 01", {mem_req, stall_f});
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            mem_ack   = (k == 3);
            mem_rdata = (k == 3) ? 32'hE3A01005 : $urandom;
            @(negedge clk);
            n_total++;
            if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100})
                $display("FAIL fetch_bus c%0d: got %b %b %h want 1 0 00000100", k, mem_req, mem_we, mem_addr);
            else n_pass++;
            n_total++;
            if ({i_ready, stall_f, bus_err} !== {k == 3, k != 3, 1'b0})
                $display("FAIL fetch_ctrl c%0d: got %b want %b", k, {i_ready, stall_f, bus_err}, {k == 3, k != 3, 1'b0});
            else n_pass++;
            n_total++;
            if (i_rdata !== ((k == 3) ? 32'hE3A01005 : 32'h0))
                $display("FAIL fetch_rdata c%0d: got %h want %h", k, i_rdata, (k == 3) ? 32'hE3A01005 : 32'h0);
            else n_pass++;
        end
        next_cycle();
        i_req = 0; mem_ack = 0;
        @(negedge clk);
        n_total++;
        if ({mem_req, i_ready, stall_f} !== 3'b0)
            $display("FAIL fetch_done: got %b want 000", {mem_req, i_ready, stall_f});
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [31:0] r;
        do_reset();
        i_req = 1; i_addr = 32'h300;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        next_cycle();
        r = $urandom;
        mem_ack = 1; mem_rdata = r;
        @(negedge clk);
        n_total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h200, 32'hDEADBEEF})
            $display("FAIL cont_d_bus: got %b %b %h %h want 1 1 00000200 deadbeef", mem_req, mem_we, mem_addr, mem_wdata);
        else n_pass++;
        n_total++;
        if ({d_ready, i_ready, stall_f, stall_m, d_rdata} !== {4'b1010, r})
            $display("FAIL cont_d_done: got %b %h want 1010 %h", {d_ready, i_ready, stall_f, stall_m}, d_rdata, r);
        else n_pass++;
        next_cycle();
        d_req = 0; mem_ack = 0;
        @(negedge clk);
        n_total++;
        if ({mem_req, stall_f} !== 2'b01)
            $display("FAIL cont_idle_gap: got %b want 01", {mem_req, stall_f});
        else n_pass++;
        next_cycle();
        r = $urandom;
        mem_ack = 1; mem_rdata = r;
        @(negedge clk);
        n_total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, i_ready, i_rdata} !== {2'b10, 32'h300, 32'h0, 1'b1, r})
            $display("FAIL cont_i_grant: got %b %b %h %h %b %h", mem_req, mem_we, mem_addr, mem_wdata, i_ready, i_rdata);
        else n_pass++;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        int w;
        do_reset();
        i_req = 1; i_addr = 32'h1000;
        d_req = 1; d_we = 0; d_addr = 32'h2000;
        for (int a = 0; a < 4; a++) begin
            w = 0;
            do begin
                next_cycle();
                mem_ack = 0;
                @(negedge clk);
                w++;
            end while (!mem_req && w < 6);
            n_total++;
            if ({mem_req, mem_addr} !== {1'b1, (a % 2 == 0) ? 32'h2000 : 32'h1000})
                $display("FAIL rr_order a%0d: got %b %h want 1 %h", a, mem_req, mem_addr, (a % 2 == 0) ? 32'h2000 : 32'h1000);
            else n_pass++;
            next_cycle();
            mem_ack = 1; mem_rdata = $urandom;
            @(negedge clk);
            n_total++;
            if ({i_ready, d_ready} !== ((a % 2 == 0) ? 2'b01 : 2'b10))
                $display("FAIL rr_ready a%0d: got %b want %b", a, {i_ready, d_ready}, (a % 2 == 0) ? 2'b01 : 2'b10);
            else n_pass++;
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h44;
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            mem_ack = 0; mem_rdata = $urandom;
            @(negedge clk);
            n_total++;
            if ({mem_req, d_ready, bus_err, stall_m} !== {1'b1, k == 3, k == 3, k != 3})
                $display("FAIL timeout c%0d: got %b want %b", k, {mem_req, d_ready, bus_err, stall_m}, {1'b1, k == 3, k == 3, k != 3});
            else n_pass++;
            n_total++;
            if (d_rdata !== 32'h0)
                $display("FAIL timeout_rdata c%0d: got %h want 00000000", k, d_rdata);
            else n_pass++;
            next_cycle();
        end
        d_req = 0;
        @(negedge clk);
        n_total++;
        if ({mem_req, bus_err, d_ready} !== 3'b0)
            $display("FAIL timeout_idle: got %b want 000", {mem_req, bus_err, d_ready});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        do_reset();
        i_req = 1; i_addr = 32'h500;
        next_cycle();
        @(negedge clk);
        n_total++;
        if (mem_req !== 1'b1) $display("FAIL rmid_grant: got %b want 1", mem_req);
        else n_pass++;
        next_cycle();
        reset = 1; i_req = 0;
        #1;
        n_total++;
        if ({mem_req, i_ready} !== 2'b00) $display("FAIL rmid_async: got %b want 00", {mem_req, i_ready});
        else n_pass++;
        next_cycle();
        reset = 0; mem_ack = 1; mem_rdata = $urandom;
        @(negedge clk);
        n_total++;
        if ({mem_req, i_ready, d_ready, i_rdata} !== 35'h0)
            $display("FAIL rmid_late_ack: got %b %b %b %h want 0 0 0 0", mem_req, i_ready, d_ready, i_rdata);
        else n_pass++;
        next_cycle();
        mem_ack = 0; i_req = 1; i_addr = 32'h600;
        @(negedge clk);
        n_total++;
        if (mem_req !== 1'b0) $display("FAIL rmid_idle: got %b want 0", mem_req);
        else n_pass++;
        next_cycle();
        r = $urandom;
        mem_ack = 1; mem_rdata = r;
        @(negedge clk);
        n_total++;
        if ({mem_req, mem_addr, i_ready, i_rdata} !== {1'b1, 32'h600, 1'b1, r})
            $display("FAIL rmid_regrant: got %b %h %b %h want 1 00000600 1 %h", mem_req, mem_addr, i_ready, i_rdata, r);
        else n_pass++;
        next_cycle();
        clear_inputs();
    endtask

    // Transaction-level model: each access is described by its grant cycle and a chosen
    // ack delay; completion cycle and outcome follow arithmetically from TO.
    task automatic test_random();
        int          last, who, st, en, dly;
        bit          ok, in_gnt, fin, exp_ir, exp_dr, exp_be;
        bit          i_act, d_act, i_owe, d_owe, c_we, dwe;
        logic [31:0] c_addr, c_wd, c_rd, ia, da, dwd;
        do_reset();
        last = 0; who = 0; st = 0; en = -1; dly = 0; ok = 0;
        i_act = 0; d_act = 0; i_owe = 0; d_owe = 0;
        c_we = 0; dwe = 0; c_addr = 0; c_wd = 0; c_rd = 0; ia = 0; da = 0; dwd = 0;
        for (int t = 0; t < 1500; t++) begin
            if (!i_act && !i_owe && $urandom_range(2) == 0) begin
                i_act = 1; ia = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_act && !d_owe && $urandom_range(2) == 0) begin
                d_act = 1; da = $urandom & 32'hFFFF_FFFC; dwd = $urandom; dwe = 1'($urandom_range(1));
            end
            if (i_act && i_owe && $urandom_range(15) == 0) i_act = 0;
            if (d_act && d_owe && $urandom_range(15) == 0) d_act = 0;

            if (t > en && (i_act || d_act)) begin
                who  = (i_act && d_act) ? 1 - last : (i_act ? 0 : 1);
                last = who;
                st   = t + 1;
                dly  = $urandom_range(TO);
                ok   = (dly < TO);
                en   = ok ? st + dly : st + TO - 1;
                c_rd = $urandom;
                if (who == 0) begin
                    c_addr = ia; c_we = 0; c_wd = 0; i_owe = 1;
                end else begin
                    c_addr = da; c_we = dwe; c_wd = dwd; d_owe = 1;
                end
            end
            in_gnt = (t >= st) && (t <= en);
            fin    = in_gnt && (t == en);
            exp_ir = fin && (who == 0);
            exp_dr = fin && (who == 1);
            exp_be = fin && !ok;

            i_req = i_act; i_addr = ia;
            d_req = d_act; d_addr = da; d_we = dwe; d_wdata = dwd;
            if (in_gnt && ok && t == st + dly) begin
                mem_ack = 1; mem_rdata = c_rd;
            end else begin
                mem_ack = !in_gnt && ($urandom_range(7) == 0);
                mem_rdata = $urandom;
            end

            @(negedge clk);
            n_total++;
            if (mem_req !== in_gnt) $display("FAIL rnd_mem_req t%0d: got %b want %b", t, mem_req, in_gnt);
            else n_pass++;
            if (in_gnt) begin
                n_total++;
                if ({mem_addr, mem_we, mem_wdata} !== {c_addr, c_we, c_wd})
                    $display("FAIL rnd_bus t%0d: got %h %b %h want %h %b %h", t, mem_addr, mem_we, mem_wdata, c_addr, c_we, c_wd);
                else n_pass++;
            end
            n_total++;
            if ({i_ready, d_ready, bus_err} !== {exp_ir, exp_dr, exp_be})
                $display("FAIL rnd_ready t%0d: got %b want %b", t, {i_ready, d_ready, bus_err}, {exp_ir, exp_dr, exp_be});
            else n_pass++;
            n_total++;
            if ({i_rdata, d_rdata} !== {(exp_ir && ok) ? c_rd : 32'h0, (exp_dr && ok) ? c_rd : 32'h0})
                $display("FAIL rnd_rdata t%0d: got %h %h want data %h on ack only", t, i_rdata, d_rdata, c_rd);
            else n_pass++;
            n_total++;
            if ({stall_f, stall_m} !== {i_act && !exp_ir, d_act && !exp_dr})
                $display("FAIL rnd_stall t%0d: got %b want %b", t, {stall_f, stall_m}, {i_act && !exp_ir, d_act && !exp_dr});
            else n_pass++;

            if (exp_ir) begin i_owe = 0; i_act = 0; end
            if (exp_dr) begin d_owe = 0; d_act = 0; end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_lone_fetch();
        test_contention();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles a granted access waits for mem_ack before abort; legal range 2..65535.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_req  input  1  fetch-stage read request; held until i_ready.
REQ-005 i_addr  input  32  fetch address; stable while i_req.
REQ-006 i_rdata  output  32  fetch read data; valid when i_ready.
REQ-007 i_ready  output  1  fetch access complete, one-cycle pulse.
REQ-008 d_req  input  1  MEM-stage request (load or store); held until d_ready.
REQ-009 d_we  input  1  1 = store, 0 = load; stable while d_req.
REQ-010 d_addr, d_wdata  input  32 each  MEM-stage address and store data (ALUResultM, WriteDataM); stable while d_req.
REQ-011 d_rdata  output  32  load data; valid when d_ready.
REQ-012 d_ready  output  1  MEM access complete, one-cycle pulse.
REQ-013 mem_req, mem_we  output  1 each  single-port memory request and write enable, registered.
REQ-014 mem_addr, mem_wdata  output  32 each  memory address and write data, registered.
REQ-015 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-016 mem_ack  input  1  memory completion, one-cycle pulse.
REQ-017 stall_f, stall_m  output  1 each  pipeline stall for fetch / MEM stage.
REQ-018 bus_err  output  1  one-cycle pulse: granted access aborted by timeout.

Function
REQ-019 FSM states IDLE, GNT_I, GNT_D; IDLE samples requests, GNT_* holds one outstanding memory access.
REQ-020 IDLE, only one of i_req/d_req high: grant that requester at next edge.
REQ-021 IDLE, both high: grant the requester not in last_grant (round-robin); last_grant resets to I, so first contention grants D.
REQ-022 On grant edge: mem_req=1, mem_addr/mem_we/mem_wdata latched from granted port (fetch: mem_we=0, mem_wdata=0); last_grant updated.
REQ-023 mem_req, mem_addr, mem_we, mem_wdata SHALL remain constant throughout GNT_*.
REQ-024 i_ready = (state==GNT_I) && (mem_ack || timeout_hit); d_ready likewise for GNT_D; combinational.
REQ-025 i_rdata and d_rdata = mem_rdata when mem_ack in matching state, else 32'h0.
REQ-026 On mem_ack or timeout_hit: return to IDLE, mem_req=0 at same edge; minimum one IDLE cycle between grants.
REQ-027 Access latency: request sampled at edge N -> mem_req high from N+1; ready in cycle of mem_ack.
REQ-028 Wait counter cleared on grant, increments each GNT_* cycle without mem_ack; timeout_hit when counter == TIMEOUT-1 and mem_ack=0.
REQ-029 bus_err = timeout_hit; ready pulses with it; rdata = 0.
REQ-030 mem_ack in IDLE SHALL be ignored: no ready, no state change.
REQ-031 mem_ack and timeout_hit in the same cycle: ack wins, bus_err=0.
REQ-032 stall_f = i_req && !i_ready; stall_m = d_req && !d_ready; combinational.
REQ-033 Requests deasserted during GNT_* SHALL not cancel the outstanding memory access.

Reset
REQ-034 Reset: state=IDLE, last_grant=I, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; hence all ready, stall-on-grant and bus_err outputs 0.
REQ-035 Reset mid-access abandons the transaction; a late mem_ack after reset SHALL be ignored per REQ-030.

Structure
REQ-036 Package mem_arb_pkg holds state enum (IDLE, GNT_I, GNT_D), grant enum (GRANT_I, GRANT_D) and width constant ADDR_W=32.
REQ-037 Single module, no sub-modules; counter width $clog2(TIMEOUT+1).

Verification
REQ-038 Lone fetch: i_req, i_addr=0x100, mem_ack 3 cycles after mem_req with rdata=0xE3A01005 -> mem_addr=0x100, mem_we=0, i_ready one cycle, i_rdata=0xE3A01005, stall_f high until then.
REQ-039 Contention after reset: i_req and d_req (store, addr 0x200, data 0xDEADBEEF) same cycle -> D granted first (mem_we=1), then I after one IDLE cycle.
REQ-040 Round-robin: both requesters held continuously for 4 accesses -> grant order D, I, D, I.
REQ-041 Timeout: TIMEOUT=4, no mem_ack -> bus_err and d_ready pulse in 4th GNT_D cycle, d_rdata=0, FSM back to IDLE.
REQ-042 Reset mid-access: assert reset during GNT_I, then mem_ack after release -> mem_req=0 immediately, no i_ready, next i_req granted normally.
REQ-043 Ack/timeout tie: TIMEOUT=4, mem_ack in 4th cycle -> ready=1, bus_err=0, correct rdata.
